// File: rtl/gf180mcu_fd_sc_mcu7t5v0_pwr_pkg.sv
// Shared types for the power-switch sequencer.
// Holds the FSM state encoding and the stage-timer width helper.
package gf180mcu_fd_sc_mcu7t5v0_pwr_pkg;

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_ON        = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } pwr_state_e;

  function automatic int tmr_w(input int steps);
    if (steps < 1) return 1;
    return $clog2(steps + 1);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0_pwr_sw_seq_if.sv
// Request/acknowledge bundle between a domain controller
// and the power-switch sequencer.
interface gf180mcu_fd_sc_mcu7t5v0_pwr_sw_seq_if #(
  parameter int NUM_SW = 8
);
  logic              EN;
  logic              FORCE_OFF;
  logic [NUM_SW-1:0] SW_EN;
  logic              ACK_ON;
  logic              ACK_OFF;

  modport master (
    output EN, FORCE_OFF,
    input  SW_EN, ACK_ON, ACK_OFF
  );

  modport slave (
    input  EN, FORCE_OFF,
    output SW_EN, ACK_ON, ACK_OFF
  );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0_pwr_seq_timer.sv
// Stage timer: counts STEPS clocks after a clear and pulses
// expire for one cycle; holds saturated once past the pulse.
module gf180mcu_fd_sc_mcu7t5v0_pwr_seq_timer
  import gf180mcu_fd_sc_mcu7t5v0_pwr_pkg::*;
#(
  parameter int STEPS = 4,
  localparam int W    = tmr_w(STEPS)
) (
  input  logic CLK,
  input  logic RN,
  input  logic clr,
  output logic expire
);

  localparam logic [W-1:0] LAST = W'(STEPS - 1);
  localparam logic [W-1:0] SAT  = W'(STEPS);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (cnt_q != SAT)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == LAST);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0_pwr_sw_seq.sv
// Power-switch sequencer: ramps a thermometer chain of header
// enables up or down one stage per timer expiry, with acks.
module gf180mcu_fd_sc_mcu7t5v0_pwr_sw_seq
  import gf180mcu_fd_sc_mcu7t5v0_pwr_pkg::*;
#(
  parameter int NUM_SW      = 8,
  parameter int STEP_CYCLES = 4,
  localparam int LVL_W      = $clog2(NUM_SW + 1)
) (
  input logic CLK,
  input logic RN,
  inout wire  VDD,
  inout wire  VSS,
  gf180mcu_fd_sc_mcu7t5v0_pwr_sw_seq_if.slave bus
);

  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(NUM_SW);
  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);

  // Supplies are pass-through pins for the physical cell view.
  wire unused_supply = VDD ^ VSS;

  pwr_state_e        state_q, state_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [NUM_SW-1:0] sw_en_q, sw_en_d;
  logic              ack_on_q, ack_on_d;
  logic              ack_off_q, ack_off_d;
  logic              tmr_clr;
  logic              tmr_exp;

  gf180mcu_fd_sc_mcu7t5v0_pwr_seq_timer #(
    .STEPS (STEP_CYCLES)
  ) u_timer (
    .CLK    (CLK),
    .RN     (RN),
    .clr    (tmr_clr),
    .expire (tmr_exp)
  );

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q   <= ST_OFF;
      level_q   <= '0;
      sw_en_q   <= '0;
      ack_on_q  <= 1'b0;
      ack_off_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      sw_en_q   <= sw_en_d;
      ack_on_q  <= ack_on_d;
      ack_off_q <= ack_off_d;
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (bus.FORCE_OFF) begin
      state_d = ST_OFF;
      level_d = '0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          if (bus.EN) begin
            state_d = ST_RAMP_UP;
            level_d = LVL_ONE;
          end
        end
        ST_RAMP_UP: begin
          if (!bus.EN) begin
            level_d = (level_q > LVL_ONE) ? level_q - LVL_ONE : '0;
            state_d = (level_q > LVL_ONE) ? ST_RAMP_DOWN : ST_OFF;
          end else if (tmr_exp) begin
            if (level_q < LVL_MAX) level_d = level_q + LVL_ONE;
            else                   state_d = ST_ON;
          end
        end
        ST_ON: begin
          if (!bus.EN) begin
            level_d = (level_q > LVL_ONE) ? level_q - LVL_ONE : '0;
            state_d = (level_q > LVL_ONE) ? ST_RAMP_DOWN : ST_OFF;
          end
        end
        ST_RAMP_DOWN: begin
          if (bus.EN) begin
            state_d = ST_RAMP_UP;
            if (level_q < LVL_MAX) level_d = level_q + LVL_ONE;
          end else if (tmr_exp) begin
            level_d = (level_q > LVL_ONE) ? level_q - LVL_ONE : '0;
            if (level_q <= LVL_ONE) state_d = ST_OFF;
          end
        end
        default: begin
          state_d = ST_OFF;
          level_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    sw_en_d = '0;
    for (int i = 0; i < NUM_SW; i++)
      sw_en_d[i] = (32'(level_d) > i);
    ack_on_d  = (state_d == ST_ON);
    ack_off_d = (state_d == ST_OFF);
    tmr_clr   = (state_d != state_q) || (level_d != level_q);
  end

  assign bus.SW_EN   = sw_en_q;
  assign bus.ACK_ON  = ack_on_q;
  assign bus.ACK_OFF = ack_off_q;

endmodule
